// File: rtl/mc_sync_switch_matrix.sv
`default_nettype none
// ============================================================================
// Module   : mc_sync_switch_matrix
// Brief    : Configurable N_IN x N_OUT routing matrix. Each registered output
//            selects at most one input (or none) with optional inversion.
//            Configuration is written into a shadow table and copied
//            atomically into the active table on commit, so every output
//            changes routing on the same clock edge. A clear sweep zeroes the
//            shadow table one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mc_sync_switch_matrix #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 32
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [N_IN-1:0]                               io_portSig,
  input  logic                                          io_cfgValid,
  output logic                                          io_cfgReady,
  input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0]  io_cfgAddr,
  input  logic [$clog2(N_IN+1)-1:0]                     io_cfgSel,
  input  logic                                          io_cfgInv,
  input  logic                                          io_commit,
  input  logic                                          io_clear,
  output logic                                          io_commitDone,
  output logic                                          io_cfgErr,
  output logic [N_OUT-1:0]                              io_portOut
);

  localparam int SEL_W  = $clog2(N_IN + 1);
  localparam int ADDR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  // Last index visited by the clear sweep
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_pending;
  logic                r_cfgReady;
  logic                r_commitDone;
  logic                r_cfgErr;

  logic [SEL_W-1:0]    r_sh_sel [N_OUT];
  logic [N_OUT-1:0]    r_sh_inv;
  logic [SEL_W-1:0]    r_ac_sel [N_OUT];
  logic [N_OUT-1:0]    r_ac_inv;
  logic [N_OUT-1:0]    r_portOut;

  logic                w_accept;
  logic                w_addr_bad;
  logic                w_sel_bad;
  logic [N_IN:0]       w_sig_ext;
  logic [N_OUT-1:0]    w_next_out;

  // Writes are only accepted while idle; out-of-range writes are dropped
  assign w_accept   = io_cfgValid & r_cfgReady;
  assign w_addr_bad = (32'(io_cfgAddr) >= 32'(N_OUT));
  assign w_sel_bad  = (32'(io_cfgSel) > 32'(N_IN));

  // Bit 0 is the constant-zero "unrouted" source, so sel indexes directly
  assign w_sig_ext = {io_portSig, 1'b0};

  generate
    for (genvar o = 0; o < N_OUT; o++) begin : g_out
      assign w_next_out[o] = w_sig_ext[r_ac_sel[o]] ^ r_ac_inv[o];
    end
  endgenerate

  // Control FSM: idle / one-cycle commit / N_OUT-cycle clear sweep
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pending    <= 1'b0;
      r_cfgReady   <= 1'b1;
      r_commitDone <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_clear) begin
            r_state      <= ST_CLEAR;
            r_cnt        <= '0;
            r_pending    <= io_commit;
            r_cfgReady   <= 1'b0;
            r_commitDone <= 1'b0;
          end else if (io_commit) begin
            r_state      <= ST_COMMIT;
            r_cfgReady   <= 1'b0;
            r_commitDone <= 1'b1;
          end else begin
            r_cfgReady   <= 1'b1;
            r_commitDone <= 1'b0;
          end
        end
        ST_COMMIT: begin
          r_state      <= ST_IDLE;
          r_cfgReady   <= 1'b1;
          r_commitDone <= 1'b0;
        end
        ST_CLEAR: begin
          if (r_cnt == c_LAST_IDX) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            if (r_pending | io_commit) begin
              r_state      <= ST_COMMIT;
              r_cfgReady   <= 1'b0;
              r_commitDone <= 1'b1;
            end else begin
              r_state      <= ST_IDLE;
              r_cfgReady   <= 1'b1;
              r_commitDone <= 1'b0;
            end
          end else begin
            r_cnt     <= r_cnt + 1'b1;
            r_pending <= r_pending | io_commit;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_cnt        <= '0;
          r_pending    <= 1'b0;
          r_cfgReady   <= 1'b1;
          r_commitDone <= 1'b0;
        end
      endcase
    end
  end

  // Shadow/active tables: writes and clear touch shadow, commit copies whole table
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_OUT; i++) begin
        r_sh_sel[i] <= '0;
        r_ac_sel[i] <= '0;
      end
      r_sh_inv <= '0;
      r_ac_inv <= '0;
    end else begin
      if (w_accept && !w_addr_bad && !w_sel_bad) begin
        r_sh_sel[io_cfgAddr] <= io_cfgSel;
        r_sh_inv[io_cfgAddr] <= io_cfgInv;
      end
      if (r_state == ST_CLEAR) begin
        r_sh_sel[r_cnt] <= '0;
        r_sh_inv[r_cnt] <= 1'b0;
      end
      if (r_state == ST_COMMIT) begin
        r_ac_sel <= r_sh_sel;
        r_ac_inv <= r_sh_inv;
      end
    end
  end

  // Sticky error flag for dropped out-of-range writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cfgErr <= 1'b0;
    end else if (w_accept && (w_addr_bad || w_sel_bad)) begin
      r_cfgErr <= 1'b1;
    end
  end

  // Registered routed outputs, always driven from the active table only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_portOut <= '0;
    end else begin
      r_portOut <= w_next_out;
    end
  end

  assign io_cfgReady   = r_cfgReady;
  assign io_commitDone = r_commitDone;
  assign io_cfgErr     = r_cfgErr;
  assign io_portOut    = r_portOut;

endmodule
`default_nettype wire

// File: tb/tb_mc_sync_switch_matrix.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_sync_switch_matrix
// Brief    : Randomized self-checking bench for mc_sync_switch_matrix with a
//            queue-of-busy-operations reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_sync_switch_matrix;

  localparam int N_IN   = 32;
  localparam int N_OUT  = 32;
  localparam int SEL_W  = $clog2(N_IN + 1);
  localparam int ADDR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N_IN-1:0]   sig   = '0;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] addr  = '0;
  logic [SEL_W-1:0]  sel   = '0;
  logic              inv   = 1'b0;
  logic              commit = 1'b0;
  logic              clr   = 1'b0;
  wire               ready;
  wire               done;
  wire               err;
  wire  [N_OUT-1:0]  pout;

  mc_sync_switch_matrix #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_portSig    (sig),
    .io_cfgValid   (valid),
    .io_cfgReady   (ready),
    .io_cfgAddr    (addr),
    .io_cfgSel     (sel),
    .io_cfgInv     (inv),
    .io_commit     (commit),
    .io_clear      (clr),
    .io_commitDone (done),
    .io_cfgErr     (err),
    .io_portOut    (pout)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_done = 0;

  // Reference model: tables as plain int arrays; the busy period is a queue
  // of pending operations (k >= 0 : zero shadow entry k, -1 : commit copy).
  int             m_sh_sel [N_OUT];
  bit             m_sh_inv [N_OUT];
  int             m_ac_sel [N_OUT];
  bit             m_ac_inv [N_OUT];
  int             q[$];
  bit             m_err;
  bit             m_ready;
  bit             m_done;
  logic [N_OUT-1:0] m_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_OUT; i++) begin
      m_sh_sel[i] = 0; m_sh_inv[i] = 0;
      m_ac_sel[i] = 0; m_ac_inv[i] = 0;
    end
    q.delete();
    m_err = 0; m_ready = 1; m_done = 0; m_out = '0;
  endfunction

  function automatic void model_step();
    logic [N_OUT-1:0] nxt;
    int head;
    for (int o = 0; o < N_OUT; o++)
      nxt[o] = ((m_ac_sel[o] == 0) ? 1'b0 : sig[m_ac_sel[o] - 1]) ^ m_ac_inv[o];
    if (q.size() == 0) begin
      if (valid) begin
        if (int'(addr) >= N_OUT || int'(sel) > N_IN) m_err = 1;
        else begin
          m_sh_sel[int'(addr)] = int'(sel);
          m_sh_inv[int'(addr)] = inv;
        end
      end
      if (clr) begin
        for (int k = 0; k < N_OUT; k++) q.push_back(k);
        if (commit) q.push_back(-1);
      end else if (commit) begin
        q.push_back(-1);
      end
    end else begin
      head = q[0];
      if (head < 0) begin
        for (int i = 0; i < N_OUT; i++) begin
          m_ac_sel[i] = m_sh_sel[i];
          m_ac_inv[i] = m_sh_inv[i];
        end
      end else begin
        m_sh_sel[head] = 0;
        m_sh_inv[head] = 0;
        if (commit && q[$] != -1) q.push_back(-1);
      end
      void'(q.pop_front());
    end
    m_out   = nxt;
    m_ready = (q.size() == 0);
    m_done  = (q.size() != 0) && (q[0] == -1);
  endfunction

  task automatic compare();
    chk("cfgReady",   64'(ready), 64'(m_ready));
    chk("commitDone", 64'(done),  64'(m_done));
    chk("cfgErr",     64'(err),   64'(m_err));
    chk("portOut",    64'(pout),  64'(m_out));
    if (done) n_done++;
  endtask

  // One clock: model advances on the edge, DUT is compared on the falling edge
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    @(negedge clock);
    compare();
    valid = 1'b0; commit = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input int a, input int s, input bit i);
    valid = 1'b1;
    addr  = ADDR_W'(a);
    sel   = SEL_W'(s);
    inv   = i;
    tick();
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("wait_ready_timeout", 64'(ready), 64'd1);
  endtask

  initial begin
    int lowcnt;
    model_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_out",   64'(pout),  64'd0);
    chk("reset_err",   64'(err),   64'd0);

    // Write route with commit in the same cycle; output visible from t+3
    n_done = 0;
    sig = '0;
    valid = 1'b1; addr = 3; sel = 5; inv = 1'b0; commit = 1'b1;
    tick();
    chk("done_t1", 64'(done), 64'd1);
    sig = 32'h10;
    tick();
    chk("out_t2_old", 64'(pout), 64'd0);
    tick();
    chk("out_t3_new", 64'(pout), 64'h8);
    repeat (3) tick();
    chk("done_once", 64'(n_done), 64'd1);

    // Inverted unrouted port appears only after commit
    wr(7, 0, 1'b1);
    repeat (3) tick();
    chk("p7_uncommitted", 64'(pout[7]), 64'd0);
    commit = 1'b1;
    tick();
    repeat (2) tick();
    chk("p7_committed", 64'(pout[7]), 64'd1);

    // Out-of-range select (address 40 is not encodable in 5 bits here)
    wr(9, 33, 1'b1);
    chk("err_set", 64'(err), 64'd1);
    commit = 1'b1;
    tick();
    repeat (4) tick();
    chk("err_sticky", 64'(err), 64'd1);
    chk("p9_unchanged", 64'(pout[9]), 64'd0);

    // Clear and commit together: 32 clear cycles + 1 commit cycle busy
    clr = 1'b1; commit = 1'b1;
    tick();
    lowcnt = 0;
    while (!ready && lowcnt < 100) begin
      lowcnt++;
      tick();
    end
    chk("busy_cycles", 64'(lowcnt), 64'd33);
    tick();
    for (int k = 0; k < 4; k++) begin
      sig = $urandom;
      tick();
      chk("cleared_out", 64'(pout), 64'd0);
    end

    // Reconfigure every route, then commit while inputs toggle
    for (int a = 0; a < N_OUT; a++)
      wr(a, $urandom_range(1, N_IN), bit'($urandom_range(0, 1)));
    commit = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sig = ~sig ^ N_IN'($urandom);
      tick();
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      sig    = $urandom;
      valid  = bit'($urandom_range(0, 1));
      addr   = ADDR_W'($urandom);
      sel    = ($urandom_range(0, 29) == 0) ? SEL_W'(N_IN + 1) : SEL_W'($urandom_range(0, N_IN));
      inv    = bit'($urandom_range(0, 1));
      commit = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 59) == 0);
      tick();
    end

    // Reset in the middle of a clear sweep (counter at 10)
    wait_ready();
    clr = 1'b1;
    tick();
    repeat (10) tick();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_async_out", 64'(pout), 64'd0);
    compare();
    tick();
    tick();
    reset = 1'b0;
    chk("post_rst_ready", 64'(ready), 64'd1);
    chk("post_rst_out",   64'(pout),  64'd0);
    for (int k = 0; k < 4; k++) begin
      sig = $urandom;
      tick();
    end
    chk("post_rst_quiet", 64'(pout), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
